// File: rtl/mips_tb_pkg.sv
// Shared types and constants for the CPU test-run checker harness.
package mips_tb_pkg;

    typedef enum logic [2:0] {
        S_RST,
        S_RUN,
        S_SETTLE,
        S_CMP,
        S_DONE
    } state_t;

    localparam logic HALT_ON_ADDR   = 1'b0;
    localparam logic HALT_ON_ACTIVE = 1'b1;

    localparam logic [31:0] HALT_ADDR_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR  = 32'hBFC0_0000;

endpackage

// File: rtl/mips_tb_run_checker_if.sv
// CPU-facing bus of the run checker: reset out, fetch address, active flag and v0 back.
interface mips_tb_run_checker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_reset;
    logic [ADDR_W-1:0] instr_address;
    logic              cpu_active;
    logic [DATA_W-1:0] register_v0;

    // master = checker side, slave = CPU side
    modport master (output cpu_reset, input instr_address, input cpu_active, input register_v0);
    modport slave  (input cpu_reset, output instr_address, output cpu_active, output register_v0);
endinterface

// File: rtl/mips_tb_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over enable.
module mips_tb_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && (cnt != '1))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/mips_tb_run_checker.sv
// Sequences CPU reset, times the run, detects halt or timeout and checks v0 after writeback settles.
module mips_tb_run_checker
    import mips_tb_pkg::*;
#(
    parameter int              ADDR_W         = 32,
    parameter int              DATA_W         = 32,
    parameter logic [ADDR_W-1:0] HALT_ADDR    = ADDR_W'(HALT_ADDR_DEF),
    parameter int              RESET_CYCLES   = 2,
    parameter int              SETTLE_CYCLES  = 1,
    parameter int              TIMEOUT_CYCLES = 1000,
    parameter int              CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic                  halt_mode,
    input  logic [DATA_W-1:0]     expected_v0,
    mips_tb_run_checker_if.master cpu,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [DATA_W-1:0]     halt_v0
);

    state_t            state_q, state_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              active_q, active_d;
    logic              done_d, pass_d, fail_d, timeout_d;
    logic [DATA_W-1:0] halt_v0_d;

    logic [CNT_W-1:0]  rst_cnt, settle_cnt;
    logic              rst_last, settle_last, to_hit;
    logic              addr_hit, act_fall, halt_det;
    logic              in_rst, in_run, in_settle;
    logic              run_step;

    assign in_rst    = (state_q == S_RST);
    assign in_run    = (state_q == S_RUN);
    assign in_settle = (state_q == S_SETTLE);

    assign rst_last    = (rst_cnt == CNT_W'(RESET_CYCLES - 1));
    assign settle_last = (settle_cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign to_hit      = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

    // active_q is zero on run entry, so a CPU idle from the start never looks like a fall
    assign addr_hit = (cpu.instr_address == HALT_ADDR);
    assign act_fall = active_q && !cpu.cpu_active;
    assign halt_det = (halt_mode == HALT_ON_ADDR) ? addr_hit : act_fall;

    // cycle_count freezes on the halt or timeout edge
    assign run_step = clk_enable && in_run && !halt_det && !to_hit;

    mips_tb_sat_counter #(.W(CNT_W)) u_rst_cnt (
        .clk  (clk),
        .rst_n(reset),
        .en   (clk_enable && in_rst),
        .clr  (clk_enable && !in_rst),
        .cnt  (rst_cnt)
    );

    mips_tb_sat_counter #(.W(CNT_W)) u_run_cnt (
        .clk  (clk),
        .rst_n(reset),
        .en   (run_step),
        .clr  (clk_enable && in_rst),
        .cnt  (cycle_count)
    );

    mips_tb_sat_counter #(.W(CNT_W)) u_settle_cnt (
        .clk  (clk),
        .rst_n(reset),
        .en   (clk_enable && in_settle),
        .clr  (clk_enable && in_rst),
        .cnt  (settle_cnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_RST;
            cpu_reset_q <= 1'b1;
            active_q    <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            halt_v0     <= '0;
        end else begin
            state_q     <= state_d;
            cpu_reset_q <= cpu_reset_d;
            active_q    <= active_d;
            done        <= done_d;
            pass        <= pass_d;
            fail        <= fail_d;
            timeout     <= timeout_d;
            halt_v0     <= halt_v0_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cpu_reset_d = cpu_reset_q;
        active_d    = active_q;
        done_d      = done;
        pass_d      = pass;
        fail_d      = fail;
        timeout_d   = timeout;
        halt_v0_d   = halt_v0;
        if (clk_enable) begin
            case (state_q)
                S_RST: begin
                    if (rst_last) begin
                        cpu_reset_d = 1'b0;
                        active_d    = 1'b0;
                        state_d     = S_RUN;
                    end
                end
                S_RUN: begin
                    active_d = cpu.cpu_active;
                    if (halt_det) begin
                        state_d = (SETTLE_CYCLES == 0) ? S_CMP : S_SETTLE;
                    end else if (to_hit) begin
                        timeout_d = 1'b1;
                        fail_d    = 1'b1;
                        done_d    = 1'b1;
                        state_d   = S_DONE;
                    end
                end
                S_SETTLE: begin
                    if (settle_last)
                        state_d = S_CMP;
                end
                S_CMP: begin
                    halt_v0_d = cpu.register_v0;
                    pass_d    = (cpu.register_v0 == expected_v0);
                    fail_d    = (cpu.register_v0 != expected_v0);
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
                default: ;
            endcase
        end
    end

    assign cpu.cpu_reset = cpu_reset_q;

endmodule

// File: tb/tb_mips_tb_run_checker.sv
// Table-driven bench for mips_tb_run_checker with a scoreboard of expected run results.
module tb_mips_tb_run_checker;
    import mips_tb_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b1;
    logic        halt_mode = 1'b0;
    logic [31:0] expected_v0 = '0;
    logic        done, pass, fail, timeout;
    logic [15:0] cycle_count;
    logic [31:0] halt_v0;

    int n_checks = 0;
    int n_err    = 0;

    mips_tb_run_checker_if #(.ADDR_W(32), .DATA_W(32)) cpu_bus ();

    mips_tb_run_checker #(
        .ADDR_W(32), .DATA_W(32), .HALT_ADDR(32'h0), .RESET_CYCLES(2),
        .SETTLE_CYCLES(1), .TIMEOUT_CYCLES(TO), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .halt_mode(halt_mode),
        .expected_v0(expected_v0), .cpu(cpu_bus), .done(done), .pass(pass),
        .fail(fail), .timeout(timeout), .cycle_count(cycle_count), .halt_v0(halt_v0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        int          act_hi;   // run cycles cpu_active is high
        int          halt_at;  // run cycle with instr_address==0, -1 = never
        logic [31:0] v0;
        logic [31:0] exp_v0;
        int          exp_cnt;
        logic        exp_pass, exp_fail, exp_to;
        logic [31:0] exp_hv0;
        int          exp_lat;  // edges from reset release to done visible
    } vec_t;

    typedef struct {
        int          cnt;
        logic        p, f, t;
        logic [31:0] hv0;
        int          lat;
    } res_t;

    vec_t vecs[8];
    res_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input int k);
        cpu_bus.cpu_active    = (k < v.act_hi);
        cpu_bus.instr_address = (k == v.halt_at) ? 32'h0 : RESET_VECTOR + 32'(4 * k);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        chk("rst_cpu_reset", cpu_bus.cpu_reset, 1);
        chk("rst_outs", {done, pass, fail, timeout}, 0);
        chk("rst_cnt", cycle_count, 0);
        chk("rst_hv0", halt_v0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_hold", cpu_bus.cpu_reset, 1);
        @(posedge clk); #1;
        chk("rst_release", cpu_bus.cpu_reset, 0);
    endtask

    task automatic run_vec(input vec_t v);
        res_t e;
        int   k;
        halt_mode            = v.mode;
        expected_v0          = v.exp_v0;
        cpu_bus.register_v0  = v.v0;
        apply_reset();
        sb.push_back('{v.exp_cnt, v.exp_pass, v.exp_fail, v.exp_to, v.exp_hv0, v.exp_lat});
        k = 0;
        while (!done && k < 40) begin
            drive(v, k);
            @(posedge clk); #1;
            k++;
        end
        e = sb.pop_front();
        if (!done) begin
            chk("done_wait", 0, 1);
            return;
        end
        chk("latency", 2 + k, e.lat);
        chk("cycle_count", cycle_count, e.cnt);
        chk("pass_fail_to", {pass, fail, timeout}, {e.p, e.f, e.t});
        chk("halt_v0", halt_v0, e.hv0);
        repeat (3) begin
            drive(v, k++);
            @(posedge clk); #1;
        end
        chk("hold_flags", {done, pass, fail, timeout, cpu_bus.cpu_reset}, {1'b1, e.p, e.f, e.t, 1'b0});
        chk("hold_cnt", cycle_count, e.cnt);
        chk("hold_hv0", halt_v0, e.hv0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t fz;
        cpu_bus.instr_address = RESET_VECTOR;
        cpu_bus.cpu_active    = 1'b0;
        cpu_bus.register_v0   = '0;
        //        mode act halt v0            exp           cnt p     f     t     hv0           lat
        vecs[0] = '{1'b0, 1, 3, 32'd1,        32'd1,        3, 1'b1, 1'b0, 1'b0, 32'd1,        8};
        vecs[1] = '{1'b0, 1, 3, 32'd1,        32'd2,        3, 1'b0, 1'b1, 1'b0, 32'd1,        8};
        vecs[2] = '{1'b1, 5, 2, 32'hDEADBEEF, 32'hDEADBEEF, 5, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 10};
        vecs[3] = '{1'b1, 0, -1, 32'd7,       32'd7,        7, 1'b0, 1'b1, 1'b1, 32'd0,        10};
        vecs[4] = '{1'b0, 3, -1, 32'd7,       32'd7,        7, 1'b0, 1'b1, 1'b1, 32'd0,        10};
        vecs[5] = '{1'b1, 1, -1, 32'd5,       32'd6,        1, 1'b0, 1'b1, 1'b0, 32'd5,        6};
        vecs[6] = '{1'b0, 0, 0, 32'd0,        32'd0,        0, 1'b1, 1'b0, 1'b0, 32'd0,        5};
        vecs[7] = '{1'b0, 0, 7, 32'd9,        32'd9,        7, 1'b1, 1'b0, 1'b0, 32'd9,        12};

        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // freeze in S_RUN: counter holds and a halt address is ignored while disabled
        fz = vecs[4];
        halt_mode = fz.mode;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            drive(fz, k);
            @(posedge clk); #1;
        end
        chk("pre_freeze_cnt", cycle_count, 3);
        clk_enable = 1'b0;
        cpu_bus.instr_address = 32'h0;
        repeat (4) @(posedge clk);
        #1;
        chk("freeze_cnt", cycle_count, 3);
        chk("freeze_done", done, 0);
        chk("freeze_cpu_reset", cpu_bus.cpu_reset, 0);
        drive(fz, 3);
        clk_enable = 1'b1;
        @(posedge clk); #1;
        chk("unfreeze_cnt", cycle_count, 4);

        // reset mid-run, then the whole sequence must repeat
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
